crypto_wallet_pi_led: RTL

Avalon-MM slave output port for the wallet's status LEDs. It is the write-side counterpart of the switch input port.
- Holds a CPU-writable output register with atomic set and clear.
- Adds a hardware one-shot pulse mode: the CPU flashes LEDs for a programmed time without software timing.
- Sits on the Nios data bus next to the other PIOs and drives out_port directly to the board pins.

---
 rtl/crypto_wallet_pi_led_pkg.sv | 26 ++
 rtl/crypto_wallet_pi_led_pulse_timer.sv | 79 +++++++
 rtl/crypto_wallet_pi_led.sv | 100 ++++++++++
 3 files changed

// File: rtl/crypto_wallet_pi_led_pkg.sv
//------------------------------------------------------------------------------
// Module   : crypto_wallet_pi_led_pkg
// Brief    : Register map and shared types for the status-LED output port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package crypto_wallet_pi_led_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PINS      = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  localparam int BUSY_BIT = 31;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_t;

endpackage

`default_nettype wire

// File: rtl/crypto_wallet_pi_led_pulse_timer.sv
//------------------------------------------------------------------------------
// Module   : crypto_wallet_pi_led_pulse_timer
// Brief    : Prescaled down-counter timing the one-shot LED pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crypto_wallet_pi_led_pulse_timer
  import crypto_wallet_pi_led_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int PRESCALE  = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 expire
);

  localparam int                 c_pw        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0]    c_presc_max = c_pw'(PRESCALE - 1);
  localparam logic [c_pw-1:0]    c_presc_one = c_pw'(1);
  localparam logic [CNT_WIDTH-1:0] c_tick_one = CNT_WIDTH'(1);

  pulse_state_t         r_state, w_state_nxt;
  logic [c_pw-1:0]      r_presc, w_presc_nxt;
  logic [CNT_WIDTH-1:0] r_tick_cnt, w_tick_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_tick_cnt <= w_tick_nxt;
    end
  end

  // A load in the expiry cycle overrides the expiry, so expire stays low then.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = r_tick_cnt;
    expire      = 1'b0;
    if (load) begin
      w_presc_nxt = '0;
      w_tick_nxt  = len;
      if (len != '0) w_state_nxt = ST_ACTIVE;
      else           w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (r_presc == c_presc_max) begin
            w_presc_nxt = '0;
            w_tick_nxt  = r_tick_cnt - c_tick_one;
            if (r_tick_cnt == c_tick_one) begin
              expire      = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_presc_nxt = r_presc + c_presc_one;
          end
        end
        default: begin
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  assign busy = (r_tick_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/crypto_wallet_pi_led.sv
//------------------------------------------------------------------------------
// Module   : crypto_wallet_pi_led
// Brief    : Avalon-MM LED output port with set/clear and hardware one-shot pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crypto_wallet_pi_led
  import crypto_wallet_pi_led_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = 16,
  parameter int                    PRESCALE    = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_pulse_mask;
  logic [CNT_WIDTH-1:0]  r_pulse_len;
  logic [31:0]           w_rdata;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_wr;
  logic                  w_trigger;
  logic                  w_busy;
  logic                  w_expire;
  logic                  w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_trigger      = w_wr && (address == ADDR_PULSE) &&
                          (r_pulse_len != '0) && (w_wdata != '0);

  crypto_wallet_pi_led_pulse_timer #(
    .CNT_WIDTH (CNT_WIDTH),
    .PRESCALE  (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_trigger),
    .len     (r_pulse_len),
    .busy    (w_busy),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_pulse_len <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:      r_data      <= w_wdata;
        ADDR_OUTSET:    r_data      <= r_data | w_wdata;
        ADDR_OUTCLEAR:  r_data      <= r_data & ~w_wdata;
        ADDR_PULSE_LEN: r_pulse_len <= writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Trigger takes priority so a retrigger on the expiry edge keeps old bits lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_pulse_mask <= '0;
    else if (w_trigger) r_pulse_mask <= r_pulse_mask | w_wdata;
    else if (w_expire)  r_pulse_mask <= '0;
  end

  assign out_port = r_data | r_pulse_mask;

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:      w_rdata[DATA_WIDTH-1:0] = r_data;
      ADDR_PINS:      w_rdata[DATA_WIDTH-1:0] = out_port;
      ADDR_PULSE: begin
        w_rdata[DATA_WIDTH-1:0] = r_pulse_mask;
        w_rdata[BUSY_BIT]       = w_busy;
      end
      ADDR_PULSE_LEN: w_rdata[CNT_WIDTH-1:0]  = r_pulse_len;
      default:        w_rdata                 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

endmodule

`default_nettype wire
